// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU issuer and any ALU responder on its port.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: opcode enum (same encoding the responder decodes), issuer FSM
// state enum, data width, and the shift distance at which SHL runs out of bits.
package alu_seq_pkg;

  localparam int DATA_W = 8;

  // A shift by this many bits or more moves every bit out of an 8-bit word.
  localparam logic [DATA_W-1:0] SHL_LIMIT = 8'd8;

  typedef enum logic [1:0] {
    OP_XOR  = 2'd0,
    OP_SHL  = 2'd1,
    OP_MOD  = 2'd2,
    OP_NAND = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_seq_issuer.sv
// Issues one command at a time to an external combinational ALU and returns its result.
// Latency: accept at edge N, result captured at N+1, rsp_valid visible from N+2; period >= 3 cycles.
// Backpressure: rsp_data/rsp_err/rsp_valid hold until rsp_ready; cmd_ready stays low until that handshake.
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake; cmd_op/cmd_a/cmd_b carry the command
//   alu_op/alu_a/alu_b       registered request lines to the ALU (change only on accept)
//   alu_out                  combinational ALU result, sampled only in the issue cycle
//   rsp_valid/rsp_ready      response handshake; rsp_data/rsp_err carry the response
//   done_count               completed responses, 8-bit, wraps silently
//
// Build option: define ALU_SEQ_ERR_CHECK_EN to flag MOD-by-zero and SHL by >= 8
// (rsp_err=1, rsp_data=0). Without it rsp_err is always 0 and rsp_data is alu_out.
module alu_seq_issuer
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [DATA_W-1:0] done_count
);

  seq_state_t state;

  // Result as it would be captured this cycle; only used in ST_ISSUE, where
  // alu_op/a/b have been stable for a full cycle and alu_out has settled.
  logic [DATA_W-1:0] issue_data;
  logic              issue_err;

  always_comb begin
    issue_data = alu_out;
    issue_err  = 1'b0;
`ifdef ALU_SEQ_ERR_CHECK_EN
    // Operand-only check: the ALU's answer for these cases is meaningless,
    // so it is replaced rather than passed through.
    if ((alu_op == OP_MOD && alu_b == '0) ||
        (alu_op == OP_SHL && alu_b >= SHL_LIMIT)) begin
      issue_data = '0;
      issue_err  = 1'b1;
    end
`endif
  end

  // Single FSM; every output is a register so cmd_ready depends on state only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      alu_op     <= 2'd0;
      alu_a      <= '0;
      alu_b      <= '0;
      done_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            alu_op    <= cmd_op;
            alu_a     <= cmd_a;
            alu_b     <= cmd_b;
            cmd_ready <= 1'b0;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rsp_data  <= issue_data;
          rsp_err   <= issue_err;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          // rsp_valid is known high here, so rsp_ready alone completes the handshake.
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            cmd_ready  <= 1'b1;
            done_count <= done_count + 8'd1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_issuer.sv
// Bench for alu_seq_issuer paired with a behavioural ALU responder.
// Latency/backpressure expectations come from a transaction-level reference model.
// Stimulus: directed test-plan cases, a randomized phase, then a 256-command wrap run.
module tb_alu_seq_issuer;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic [1:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_out;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [7:0] done_count;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  // Garbage added to alu_out in every cycle that is not the issue cycle.
  logic [7:0] noise = 8'h00;

  always #5 clk = ~clk;

  alu_seq_issuer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .done_count(done_count)
  );

  // Behavioural ALU responder (modulo by zero answers 0xFF).
  function automatic logic [7:0] alu_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'd0:    return a ^ b;
      2'd1:    return a << b;
      2'd2:    return (b == 8'd0) ? 8'hFF : a % b;
      default: return ~(a & b);
    endcase
  endfunction

  assign alu_out = alu_fn(alu_op, alu_a, alu_b) ^ noise;

  // Expected {err, data} for a command.
  function automatic logic [8:0] expect_rsp(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
`ifdef ALU_SEQ_ERR_CHECK_EN
    if ((op == 2'd2 && b == 8'd0) || (op == 2'd1 && b >= 8'd8)) return 9'h100;
`endif
    return {1'b0, alu_fn(op, a, b)};
  endfunction

  // Reference model: one command in flight; m_age counts cycles since accept
  // (0 = the issue cycle, >=1 = response offered).
  bit         m_busy = 1'b0;
  int         m_age  = 0;
  logic [1:0] m_op   = 2'd0;
  logic [7:0] m_a    = 8'd0, m_b = 8'd0, m_cnt = 8'd0;
  bit         m_acc  = 1'b0, m_hs = 1'b0;

  always @(posedge clk) begin
    m_acc = 1'b0;
    m_hs  = 1'b0;
    if (reset) begin
      m_busy = 1'b0; m_age = 0; m_op = 2'd0; m_a = 8'd0; m_b = 8'd0; m_cnt = 8'd0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_busy = 1'b1; m_age = 0; m_op = cmd_op; m_a = cmd_a; m_b = cmd_b; m_acc = 1'b1;
      end
    end else if (m_age >= 1 && rsp_ready) begin
      m_busy = 1'b0; m_cnt = m_cnt + 8'd1; m_hs = 1'b1;
    end else if (m_age < 4) begin
      m_age = m_age + 1;
    end
  end

  always @(posedge clk) begin
    #1;
    noise = (m_busy && m_age == 0) ? 8'h00 : 8'($urandom);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL timeout %s at %0t", name, $time);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin : cmp
    logic [8:0] e;
    if (run_cmp) begin
      chk("cmd_ready", 8'(cmd_ready), 8'(!m_busy));
      chk("rsp_valid", 8'(rsp_valid), 8'(m_busy && m_age >= 1));
      if (m_busy && m_age >= 1) begin
        e = expect_rsp(m_op, m_a, m_b);
        chk("rsp_data", rsp_data, e[7:0]);
        chk("rsp_err", 8'(rsp_err), 8'(e[8]));
      end
      chk("alu_op", 8'(alu_op), 8'(m_op));
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("done_count", done_count, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    do begin tick(); n++; end while (!m_acc && n < 40);
    if (!m_acc) timeout("send");
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string name, input logic [7:0] ed, input logic ee, input int stall);
    int n = 0;
    rsp_ready = 1'b0;
    while (!(m_busy && m_age >= 1) && n < 40) begin tick(); n++; end
    if (n >= 40) timeout({name, "_wait"});
    chk({name, "_data"}, rsp_data, ed);
    chk({name, "_err"}, 8'(rsp_err), 8'(ee));
    repeat (stall) tick();
    rsp_ready = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!m_hs && n < 40);
    if (!m_hs) timeout({name, "_hs"});
    rsp_ready = 1'b0;
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_rsp_valid"}, 8'(rsp_valid), 8'h00);
    chk({name, "_cmd_ready"}, 8'(cmd_ready), 8'h01);
    chk({name, "_alu_op"}, 8'(alu_op), 8'h00);
    chk({name, "_alu_a"}, alu_a, 8'h00);
    chk({name, "_alu_b"}, alu_b, 8'h00);
    chk({name, "_done"}, done_count, 8'h00);
  endtask

  initial begin
    int n;
    int hs;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_a = 8'd0; cmd_b = 8'd0; rsp_ready = 1'b0;
    tick();
    run_cmp = 1'b1;
    tick();
    chk_reset_state("rst");
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_rsp_err", 8'(rsp_err), 8'h00);
    reset = 1'b0;

    // XOR: response visible exactly two edges after accept.
    send(2'd0, 8'hF0, 8'h3C);
    chk("xor_issue_valid", 8'(rsp_valid), 8'h00);
    tick();
    chk("xor_resp_valid", 8'(rsp_valid), 8'h01);
    get_rsp("xor", 8'hCC, 1'b0, 0);
    chk("xor_done", done_count, 8'h01);

    // SHL then NAND with the second command already waiting.
    send(2'd1, 8'h01, 8'h03);
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_a = 8'hFF; cmd_b = 8'h0F;
    get_rsp("shl", 8'h08, 1'b0, 2);
    chk("b2b_ready_after_hs", 8'(cmd_ready), 8'h01);
    send(2'd3, 8'hFF, 8'h0F);
    get_rsp("nand", 8'hF0, 1'b0, 0);

    // Modulo command with 5 cycles of backpressure.
    send(2'd2, 8'd200, 8'd7);
    get_rsp("mod", 8'h04, 1'b0, 5);
    chk("mod_done", done_count, 8'h04);

`ifdef ALU_SEQ_ERR_CHECK_EN
    send(2'd2, 8'h55, 8'h00);
    get_rsp("mod0", 8'h00, 1'b1, 1);
    send(2'd1, 8'hFF, 8'd9);
    get_rsp("shl9", 8'h00, 1'b1, 0);
`else
    send(2'd2, 8'h55, 8'h00);
    get_rsp("mod0", 8'hFF, 1'b0, 1);
    send(2'd1, 8'hFF, 8'd9);
    get_rsp("shl9", 8'h00, 1'b0, 0);
`endif
    chk("err_done", done_count, 8'h06);

    // Reset during ISSUE.
    send(2'd3, 8'h12, 8'h34);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_state("rst_issue");

    // Reset during RESP with a pending, unacknowledged response.
    send(2'd0, 8'h05, 8'h06);
    get_rsp("pre", 8'h03, 1'b0, 0);
    send(2'd1, 8'h12, 8'h01);
    tick();
    tick();
    chk("pre_rst_valid", 8'(rsp_valid), 8'h01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_state("rst_resp");

    // Randomized phase; the per-cycle compare does the checking.
    for (int c = 0; c < 3000; c++) begin
      cmd_valid = ($urandom % 3) != 0;
      cmd_op    = 2'($urandom);
      cmd_a     = 8'($urandom);
      case ($urandom % 4)
        0:       cmd_b = 8'd0;
        1:       cmd_b = 8'($urandom_range(0, 15));
        default: cmd_b = 8'($urandom);
      endcase
      rsp_ready = ($urandom % 2) != 0;
      reset     = ($urandom % 200) == 0;
      tick();
    end

    // Wrap: 256 back-to-back commands at full rate.
    cmd_valid = 1'b0; rsp_ready = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; cmd_valid = 1'b1; rsp_ready = 1'b1;
    n = 0; hs = 0;
    while (hs < 256 && n < 1000) begin
      cmd_op = 2'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
      tick();
      n++;
      if (m_hs) hs++;
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    if (hs < 256) timeout("wrap");
    chk("wrap_done", done_count, 8'h00);
    checks++;
    if (n != 768) begin
      errors++;
      $display("FAIL wrap_cycles got %0d expected 768", n);
    end
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
